// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers ALU and load results in private 2-entry FIFOs
// and broadcasts at most one per cycle, round-robin on ties.
module cdb_arbiter #(
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clr,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [TAG_W-1:0]  alu_tag,
  input  logic [DATA_W-1:0] alu_value,
  input  logic              alu_jump_s,
  input  logic [ADDR_W-1:0] alu_jump,
  input  logic              lsb_valid,
  output logic              lsb_ready,
  input  logic [TAG_W-1:0]  lsb_tag,
  input  logic [DATA_W-1:0] lsb_value,
  output logic              cdb_valid,
  output logic              cdb_src,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_value,
  output logic              cdb_jump_s,
  output logic [ADDR_W-1:0] cdb_jump
);

  localparam int unsigned ALU_W = TAG_W + DATA_W + 1 + ADDR_W;
  localparam int unsigned LSB_W = TAG_W + DATA_W;

  logic [ALU_W-1:0]  alu_mem_q [2];
  logic [ALU_W-1:0]  alu_mem_d [2];
  logic [LSB_W-1:0]  lsb_mem_q [2];
  logic [LSB_W-1:0]  lsb_mem_d [2];
  logic              alu_wp_q, alu_wp_d, alu_rp_q, alu_rp_d;
  logic              lsb_wp_q, lsb_wp_d, lsb_rp_q, lsb_rp_d;
  logic [1:0]        alu_cnt_q, alu_cnt_d, lsb_cnt_q, lsb_cnt_d;
  logic              last_grant_q, last_grant_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic              cdb_src_q, cdb_src_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_value_q, cdb_value_d;
  logic              cdb_jump_s_q, cdb_jump_s_d;
  logic [ADDR_W-1:0] cdb_jump_q, cdb_jump_d;

  logic              alu_push, lsb_push, alu_ne, lsb_ne, grant_alu, grant_lsb;
  logic [ALU_W-1:0]  alu_head;
  logic [LSB_W-1:0]  lsb_head;

  // Acceptance depends only on occupancy and control, never on the source's valid.
  assign alu_ready = (alu_cnt_q < 2'd2) && rdy && !clr && !rst;
  assign lsb_ready = (lsb_cnt_q < 2'd2) && rdy && !clr && !rst;

  always_comb begin
    alu_push  = alu_valid && alu_ready;
    lsb_push  = lsb_valid && lsb_ready;
    alu_ne    = (alu_cnt_q != 2'd0);
    lsb_ne    = (lsb_cnt_q != 2'd0);
    // last_grant=1 means LSB won last, so the ALU takes the next tie.
    grant_alu = rdy && !clr && alu_ne && (!lsb_ne || last_grant_q);
    grant_lsb = rdy && !clr && lsb_ne && (!alu_ne || !last_grant_q);
    alu_head  = alu_mem_q[alu_rp_q];
    lsb_head  = lsb_mem_q[lsb_rp_q];

    alu_mem_d    = alu_mem_q;
    lsb_mem_d    = lsb_mem_q;
    alu_wp_d     = alu_wp_q;
    alu_rp_d     = alu_rp_q;
    lsb_wp_d     = lsb_wp_q;
    lsb_rp_d     = lsb_rp_q;
    last_grant_d = last_grant_q;
    cdb_valid_d  = 1'b0;
    cdb_src_d    = cdb_src_q;
    cdb_tag_d    = cdb_tag_q;
    cdb_value_d  = cdb_value_q;
    cdb_jump_s_d = cdb_jump_s_q;
    cdb_jump_d   = cdb_jump_q;

    if (alu_push) begin
      alu_mem_d[alu_wp_q] = {alu_tag, alu_value, alu_jump_s, alu_jump};
      alu_wp_d            = alu_wp_q + 1'b1;
    end
    if (lsb_push) begin
      lsb_mem_d[lsb_wp_q] = {lsb_tag, lsb_value};
      lsb_wp_d            = lsb_wp_q + 1'b1;
    end

    if (grant_alu) begin
      alu_rp_d     = alu_rp_q + 1'b1;
      last_grant_d = 1'b0;
      cdb_valid_d  = 1'b1;
      cdb_src_d    = 1'b0;
      cdb_tag_d    = alu_head[ALU_W-1 -: TAG_W];
      cdb_value_d  = alu_head[ADDR_W+DATA_W : ADDR_W+1];
      cdb_jump_s_d = alu_head[ADDR_W];
      cdb_jump_d   = alu_head[ADDR_W-1:0];
    end else if (grant_lsb) begin
      lsb_rp_d     = lsb_rp_q + 1'b1;
      last_grant_d = 1'b1;
      cdb_valid_d  = 1'b1;
      cdb_src_d    = 1'b1;
      cdb_tag_d    = lsb_head[LSB_W-1 -: TAG_W];
      cdb_value_d  = lsb_head[DATA_W-1:0];
      cdb_jump_s_d = 1'b0;
      cdb_jump_d   = ADDR_W'(0);
    end

    alu_cnt_d = alu_cnt_q + {1'b0, alu_push} - {1'b0, grant_alu};
    lsb_cnt_d = lsb_cnt_q + {1'b0, lsb_push} - {1'b0, grant_lsb};

    if (clr) begin
      alu_wp_d  = 1'b0;
      alu_rp_d  = 1'b0;
      lsb_wp_d  = 1'b0;
      lsb_rp_d  = 1'b0;
      alu_cnt_d = 2'd0;
      lsb_cnt_d = 2'd0;
    end

    if (rst) begin
      alu_wp_d     = 1'b0;
      alu_rp_d     = 1'b0;
      lsb_wp_d     = 1'b0;
      lsb_rp_d     = 1'b0;
      alu_cnt_d    = 2'd0;
      lsb_cnt_d    = 2'd0;
      last_grant_d = 1'b1;
      cdb_valid_d  = 1'b0;
      cdb_src_d    = 1'b0;
      cdb_tag_d    = TAG_W'(0);
      cdb_value_d  = DATA_W'(0);
      cdb_jump_s_d = 1'b0;
      cdb_jump_d   = ADDR_W'(0);
    end
  end

  always_ff @(posedge clk) begin
    alu_mem_q    <= alu_mem_d;
    lsb_mem_q    <= lsb_mem_d;
    alu_wp_q     <= alu_wp_d;
    alu_rp_q     <= alu_rp_d;
    lsb_wp_q     <= lsb_wp_d;
    lsb_rp_q     <= lsb_rp_d;
    alu_cnt_q    <= alu_cnt_d;
    lsb_cnt_q    <= lsb_cnt_d;
    last_grant_q <= last_grant_d;
    cdb_valid_q  <= cdb_valid_d;
    cdb_src_q    <= cdb_src_d;
    cdb_tag_q    <= cdb_tag_d;
    cdb_value_q  <= cdb_value_d;
    cdb_jump_s_q <= cdb_jump_s_d;
    cdb_jump_q   <= cdb_jump_d;
  end

  assign cdb_valid  = cdb_valid_q;
  assign cdb_src    = cdb_src_q;
  assign cdb_tag    = cdb_tag_q;
  assign cdb_value  = cdb_value_q;
  assign cdb_jump_s = cdb_jump_s_q;
  assign cdb_jump   = cdb_jump_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus random traffic, all checked
// against a queue-based model of the broadcast rules.
module tb_cdb_arbiter;

  localparam int unsigned BUS_W = 71;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] value;
    logic        js;
    logic [31:0] jump;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, rdy, clr;
  logic        alu_valid, alu_ready, alu_jump_s;
  logic [3:0]  alu_tag;
  logic [31:0] alu_value, alu_jump;
  logic        lsb_valid, lsb_ready;
  logic [3:0]  lsb_tag;
  logic [31:0] lsb_value;
  logic        cdb_valid, cdb_src, cdb_jump_s;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_value, cdb_jump;
  logic [BUS_W-1:0] obs_bus;

  cdb_arbiter #(.TAG_W(4), .DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_tag(alu_tag),
    .alu_value(alu_value), .alu_jump_s(alu_jump_s), .alu_jump(alu_jump),
    .lsb_valid(lsb_valid), .lsb_ready(lsb_ready), .lsb_tag(lsb_tag),
    .lsb_value(lsb_value),
    .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_tag(cdb_tag),
    .cdb_value(cdb_value), .cdb_jump_s(cdb_jump_s), .cdb_jump(cdb_jump)
  );

  always #5 clk = ~clk;
  assign obs_bus = {cdb_valid, cdb_src, cdb_tag, cdb_value, cdb_jump_s, cdb_jump};

  // Sources' pending results (held until accepted) and the arbiter's queues.
  ent_t ap[$], lp[$], aq[$], lq[$];
  logic        m_last, m_valid, m_src, m_js;
  logic [3:0]  m_tag;
  logic [31:0] m_value, m_jump;
  logic        c_rst, c_rdy, c_clr;
  logic        e_ar, e_lr, o_ar, o_lr;
  int          n_checks = 0;
  int          n_pass = 0;

  function automatic logic [BUS_W-1:0] exp_bus();
    return {m_valid, m_src, m_tag, m_value, m_js, m_jump};
  endfunction

  function automatic ent_t rnd_ent(input logic [3:0] t);
    ent_t e;
    e.tag   = t;
    e.value = $urandom;
    e.js    = 1'($urandom_range(0, 1));
    e.jump  = $urandom;
    return e;
  endfunction

  // One clock: drive sources at negedge, sample readies, then advance the model.
  task automatic tick();
    ent_t g;
    logic a_acc, l_acc, an, ln, gs;
    @(negedge clk);
    rst = c_rst; rdy = c_rdy; clr = c_clr;
    alu_valid = (ap.size() != 0);
    lsb_valid = (lp.size() != 0);
    if (alu_valid) begin
      alu_tag = ap[0].tag; alu_value = ap[0].value; alu_jump_s = ap[0].js; alu_jump = ap[0].jump;
    end else begin
      alu_tag = 4'($urandom); alu_value = $urandom; alu_jump_s = 1'($urandom); alu_jump = $urandom;
    end
    if (lsb_valid) begin
      lsb_tag = lp[0].tag; lsb_value = lp[0].value;
    end else begin
      lsb_tag = 4'($urandom); lsb_value = $urandom;
    end
    e_ar = (aq.size() < 2) && c_rdy && !c_clr && !c_rst;
    e_lr = (lq.size() < 2) && c_rdy && !c_clr && !c_rst;
    #1;
    o_ar = alu_ready; o_lr = lsb_ready;
    a_acc = alu_valid && e_ar;
    l_acc = lsb_valid && e_lr;
    @(posedge clk);
    if (c_rst) begin
      aq.delete(); lq.delete();
      m_last = 1'b1; m_valid = 1'b0; m_src = 1'b0; m_tag = 4'd0;
      m_value = 32'd0; m_js = 1'b0; m_jump = 32'd0;
    end else if (c_clr) begin
      aq.delete(); lq.delete();
      m_valid = 1'b0;
    end else if (!c_rdy) begin
      m_valid = 1'b0;
    end else begin
      an = (aq.size() != 0);
      ln = (lq.size() != 0);
      if (an || ln) begin
        gs = an ? (ln ? !m_last : 1'b0) : 1'b1;
        m_last = gs; m_valid = 1'b1; m_src = gs;
        if (!gs) begin
          g = aq.pop_front();
          m_tag = g.tag; m_value = g.value; m_js = g.js; m_jump = g.jump;
        end else begin
          g = lq.pop_front();
          m_tag = g.tag; m_value = g.value; m_js = 1'b0; m_jump = 32'd0;
        end
      end else begin
        m_valid = 1'b0;
      end
      if (a_acc) aq.push_back(ap[0]);
      if (l_acc) lq.push_back(lp[0]);
    end
    if (a_acc) void'(ap.pop_front());
    if (l_acc) void'(lp.pop_front());
    #1;
  endtask

  task automatic do_reset();
    ap.delete(); lp.delete();
    c_rst = 1'b1; c_rdy = 1'b1; c_clr = 1'b0;
    tick();
    c_rst = 1'b0;
  endtask

  task automatic test_reset();
    c_rst = 1'b1; c_rdy = 1'b1; c_clr = 1'b1;
    tick(); tick();
    n_checks++;
    if (obs_bus !== BUS_W'(0)) $display("FAIL reset_outputs: got %h want 0", obs_bus);
    else n_pass++;
    n_checks++;
    if ({o_ar, o_lr} !== 2'b00) $display("FAIL reset_ready: got %b want 00", {o_ar, o_lr});
    else n_pass++;
    c_rst = 1'b0; c_clr = 1'b0;
  endtask

  task automatic test_single_alu();
    do_reset();
    ap.push_back('{4'd3, 32'h11, 1'b1, 32'h100});
    tick();
    n_checks++;
    if ({o_ar, cdb_valid} !== 2'b10) $display("FAIL single_edge0: ready,valid got %b want 10", {o_ar, cdb_valid});
    else n_pass++;
    tick();
    n_checks++;
    if (obs_bus !== {1'b1, 1'b0, 4'd3, 32'h11, 1'b1, 32'h100})
      $display("FAIL single_bcast: got %h want %h", obs_bus, {1'b1, 1'b0, 4'd3, 32'h11, 1'b1, 32'h100});
    else n_pass++;
    tick();
    n_checks++;
    if (obs_bus !== exp_bus() || cdb_valid !== 1'b0) $display("FAIL single_after: got %h want %h", obs_bus, exp_bus());
    else n_pass++;
  endtask

  task automatic test_tie();
    do_reset();
    ap.push_back(rnd_ent(4'd1));
    lp.push_back(rnd_ent(4'd2));
    tick(); tick();
    n_checks++;
    if ({cdb_valid, cdb_src, cdb_tag} !== {1'b1, 1'b0, 4'd1}) $display("FAIL tie_first: got %b want 1_0_0001", {cdb_valid, cdb_src, cdb_tag});
    else n_pass++;
    tick();
    n_checks++;
    if ({cdb_valid, cdb_src, cdb_tag, cdb_jump_s, cdb_jump} !== {1'b1, 1'b1, 4'd2, 1'b0, 32'd0})
      $display("FAIL tie_second: got %h want %h", {cdb_valid, cdb_src, cdb_tag, cdb_jump_s, cdb_jump}, {1'b1, 1'b1, 4'd2, 1'b0, 32'd0});
    else n_pass++;
    n_checks++;
    if (obs_bus !== exp_bus()) $display("FAIL tie_model: got %h want %h", obs_bus, exp_bus());
    else n_pass++;
    tick();
    n_checks++;
    if (cdb_valid !== 1'b0) $display("FAIL tie_idle: got %b want 0", cdb_valid);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [3:0] seen[$];
    int alu_seen = 0;
    logic saw_bp = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) lp.push_back(rnd_ent(4'(4 + i)));
    for (int i = 0; i < 10; i++) ap.push_back(rnd_ent(4'(8 + (i % 8))));
    for (int cyc = 0; cyc < 20; cyc++) begin
      tick();
      if (lsb_valid && !o_lr) saw_bp = 1'b1;
      if (cdb_valid && cdb_src) seen.push_back(cdb_tag);
      if (cdb_valid && !cdb_src) alu_seen++;
      n_checks++;
      if (obs_bus !== exp_bus() || {o_ar, o_lr} !== {e_ar, e_lr})
        $display("FAIL bp_cycle%0d: bus %h rdy %b want %h %b", cyc, obs_bus, {o_ar, o_lr}, exp_bus(), {e_ar, e_lr});
      else n_pass++;
    end
    n_checks++;
    if (seen.size() != 3 || {seen[0], seen[1], seen[2]} !== {4'd4, 4'd5, 4'd6})
      $display("FAIL bp_lsb_order: got %0d tags first %h want 3 tags 456", seen.size(), seen.size() > 0 ? seen[0] : 4'hx);
    else n_pass++;
    n_checks++;
    if (alu_seen != 10 || !saw_bp) $display("FAIL bp_alu_count: alu %0d stall %b want 10 1", alu_seen, saw_bp);
    else n_pass++;
  endtask

  task automatic test_flush();
    logic [4:0] seen[$];
    do_reset();
    ap.push_back(rnd_ent(4'd9));  ap.push_back(rnd_ent(4'd10));
    lp.push_back(rnd_ent(4'd11)); lp.push_back(rnd_ent(4'd12));
    tick(); tick();
    c_clr = 1'b1;
    tick();
    c_clr = 1'b0;
    n_checks++;
    if ({cdb_valid, o_ar, o_lr} !== 3'b000) $display("FAIL flush_edge: valid,ready got %b want 000", {cdb_valid, o_ar, o_lr});
    else n_pass++;
    ap.push_back(rnd_ent(4'd7));
    for (int cyc = 0; cyc < 5; cyc++) begin
      tick();
      if (cdb_valid) seen.push_back({cdb_src, cdb_tag});
      n_checks++;
      if (obs_bus !== exp_bus()) $display("FAIL flush_cycle%0d: got %h want %h", cyc, obs_bus, exp_bus());
      else n_pass++;
    end
    n_checks++;
    if (seen.size() != 1 || seen[0] !== 5'h07)
      $display("FAIL flush_after: got %0d broadcasts want only ALU tag 7", seen.size());
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [3:0] seen[$];
    do_reset();
    ap.push_back(rnd_ent(4'd1)); ap.push_back(rnd_ent(4'd2));
    lp.push_back(rnd_ent(4'd3)); lp.push_back(rnd_ent(4'd4));
    tick(); tick();
    c_rdy = 1'b0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      tick();
      n_checks++;
      if ({cdb_valid, o_ar, o_lr} !== 3'b000 || obs_bus !== exp_bus())
        $display("FAIL stall_cycle%0d: valid,ready %b want 000", cyc, {cdb_valid, o_ar, o_lr});
      else n_pass++;
    end
    c_rdy = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      tick();
      if (cdb_valid) seen.push_back(cdb_tag);
      n_checks++;
      if (obs_bus !== exp_bus()) $display("FAIL resume_cycle%0d: got %h want %h", cyc, obs_bus, exp_bus());
      else n_pass++;
    end
    n_checks++;
    if (seen.size() != 3 || {seen[0], seen[1], seen[2]} !== {4'd3, 4'd2, 4'd4})
      $display("FAIL stall_order: got %0d broadcasts want tags 3,2,4", seen.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      ap.push_back(rnd_ent(4'(1 + i)));
      lp.push_back(rnd_ent(4'(8 + i)));
    end
    tick(); tick(); tick();
    n_checks++;
    if (cdb_valid !== 1'b1) $display("FAIL midrst_pre: valid got %b want 1", cdb_valid);
    else n_pass++;
    c_rst = 1'b1;
    tick();
    c_rst = 1'b0;
    n_checks++;
    if (obs_bus !== BUS_W'(0) || {o_ar, o_lr} !== 2'b00)
      $display("FAIL midrst_outputs: got %h ready %b want 0 00", obs_bus, {o_ar, o_lr});
    else n_pass++;
    ap.delete(); lp.delete();
    ap.push_back(rnd_ent(4'd5));
    lp.push_back(rnd_ent(4'd6));
    tick(); tick();
    n_checks++;
    if ({cdb_valid, cdb_src, cdb_tag} !== {1'b1, 1'b0, 4'd5}) $display("FAIL midrst_tie: got %b want 1_0_0101", {cdb_valid, cdb_src, cdb_tag});
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      c_rst = ($urandom_range(0, 99) == 0);
      c_clr = ($urandom_range(0, 99) < 3);
      c_rdy = ($urandom_range(0, 99) < 85);
      if (ap.size() < 3 && $urandom_range(0, 1) == 1) ap.push_back(rnd_ent(4'($urandom)));
      if (lp.size() < 3 && $urandom_range(0, 1) == 1) lp.push_back(rnd_ent(4'($urandom)));
      tick();
      n_checks++;
      if (obs_bus !== exp_bus() || {o_ar, o_lr} !== {e_ar, e_lr})
        $display("FAIL random_cycle%0d: bus %h rdy %b want %h %b", cyc, obs_bus, {o_ar, o_lr}, exp_bus(), {e_ar, e_lr});
      else n_pass++;
    end
    c_rst = 1'b0; c_clr = 1'b0; c_rdy = 1'b1;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b0; clr = 1'b0;
    alu_valid = 1'b0; alu_tag = 4'd0; alu_value = 32'd0; alu_jump_s = 1'b0; alu_jump = 32'd0;
    lsb_valid = 1'b0; lsb_tag = 4'd0; lsb_value = 32'd0;
    m_last = 1'b1; m_valid = 1'b0; m_src = 1'b0; m_tag = 4'd0;
    m_value = 32'd0; m_js = 1'b0; m_jump = 32'd0;
    c_rst = 1'b1; c_rdy = 1'b1; c_clr = 1'b0;
    e_ar = 1'b0; e_lr = 1'b0; o_ar = 1'b0; o_lr = 1'b0;
    test_reset();
    test_single_alu();
    test_tie();
    test_backpressure();
    test_flush();
    test_stall();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The block SHALL have these parameters:
- TAG_W, 4, ROB tag width
- DATA_W, 32, result width
- ADDR_W, 32, jump-target width
REQ-002 The block SHALL have these ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rdy  in  1  global enable; low freezes the block
- clr  in  1  pipeline flush from the commit stage
- alu_valid  in  1  ALU result present
- alu_ready  out  1  ALU entry accepted this cycle
- alu_tag  in  TAG_W  ROB tag of the ALU result
- alu_value  in  DATA_W  ALU result
- alu_jump_s  in  1  branch/jump taken
- alu_jump  in  ADDR_W  jump target
- lsb_valid  in  1  load result present
- lsb_ready  out  1  load entry accepted this cycle
- lsb_tag  in  TAG_W  ROB tag of the load
- lsb_value  in  DATA_W  load data
- cdb_valid  out  1  broadcast valid (registered)
- cdb_src  out  1  0=ALU, 1=LSB (registered)
- cdb_tag  out  TAG_W  broadcast tag (registered)
- cdb_value  out  DATA_W  broadcast value (registered)
- cdb_jump_s  out  1  broadcast taken flag (registered)
- cdb_jump  out  ADDR_W  broadcast target (registered)

Function
REQ-003 Each source SHALL have a private 2-entry FIFO:
- 1-bit read and write pointers that wrap naturally
- 2-bit count, 0..2
- the LSB FIFO stores tag and value only
REQ-004 Ready outputs and accept rule:
- alu_ready = (alu_count<2) && rdy && !clr && !rst; lsb_ready is the same with lsb_count
- ready SHALL depend only on registered state and the control inputs, never on the source's own valid
- an entry is pushed at the edge when valid && ready
REQ-005 An entry pushed at edge E SHALL be eligible for grant from the cycle after E; there is no bypass, so the earliest cdb_valid is after edge E+1.
REQ-006 Grant, evaluated each cycle with rdy=1 and clr=0:
- only one FIFO non-empty: grant it
- both non-empty: grant the source not equal to last_grant (round-robin)
- neither non-empty: no grant
REQ-007 last_grant SHALL be updated to the granted source only on a grant; with no grant it SHALL hold.
REQ-008 On a grant, at the same edge:
- pop the head of the granted FIFO
- load the cdb_* registers from that entry with cdb_valid<=1 and cdb_src<=source
- for LSB entries, cdb_jump_s<=0 and cdb_jump<=0
REQ-009 With no grant, cdb_valid<=0 and the other cdb_* registers SHALL hold their values.
REQ-010 Simultaneous push and pop on one FIFO at count 1 SHALL leave count at 1 and keep the entries in FIFO order.
REQ-011 Push at count 2 is impossible because ready=0; a valid held without ready SHALL be retried by the source and never dropped or duplicated.
REQ-012 At most one broadcast SHALL occur per cycle, and entries from each source SHALL be broadcast in arrival order.
REQ-013 clr=1 (rdy ignored) at an edge SHALL:
- reset both FIFO counts and pointers to 0
- set cdb_valid<=0
- push nothing, pop nothing
- hold last_grant
REQ-014 rdy=0 and clr=0 at an edge SHALL:
- set cdb_valid<=0
- leave FIFOs, pointers, counts and last_grant unchanged
- accept nothing (ready=0)

Reset
REQ-015 rst=1 at an edge SHALL set:
- all FIFO pointers and counts to 0
- last_grant<=1 (LSB), so the ALU wins the first tie
- cdb_valid<=0, cdb_src<=0, cdb_tag<=0, cdb_value<=0, cdb_jump_s<=0, cdb_jump<=0
REQ-016 rst SHALL take priority over clr and rdy; during rst both ready outputs SHALL be 0.

Verification
REQ-017 Single ALU: alu_valid with tag=3, value=0x11, jump_s=1, jump=0x100 accepted at edge 0 -> cdb_valid=1, src=0, tag=3, value=0x11, jump_s=1, jump=0x100 after edge 1 only.
REQ-018 Tie: ALU tag 1 and LSB tag 2 both accepted at edge 0 after reset -> tag 1 (src 0) after edge 1, tag 2 (src 1, jump_s=0) after edge 2, cdb_valid=0 after edge 3.
REQ-019 Backpressure: LSB pushes tags 4, 5, 6 on consecutive cycles while the ALU FIFO streams continuously -> lsb_ready=0 while lsb_count=2, tags broadcast in order 4, 5, 6 alternating with ALU results, no loss or duplicates.
REQ-020 Flush: two entries queued per source, clr=1 for one edge -> cdb_valid=0 next cycle, both counts 0, old entries never broadcast, and a new ALU tag 7 pushed after the flush is broadcast normally.
REQ-021 Stall: rdy=0 for 3 cycles with entries queued -> cdb_valid=0 and counts frozen during the stall; broadcasts resume in the original order after rdy returns to 1.
REQ-022 Reset mid-operation: rst=1 with full FIFOs and cdb_valid=1 -> all outputs 0 next cycle, and the first tie afterwards is granted to the ALU.
